// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared single-precision float constants and the converter
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_rne
// Description : Combinational round-to-nearest-even of a normalized magnitude
//               (leading one in the MSB) into a packed exponent/mantissa.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int MAG_W = 32
) (
    input  logic [MAG_W-1:0]              mag,
    input  logic [FP_EXP_W-1:0]           exp,
    output logic [FP_EXP_W+FP_MANT_W-1:0] packed_em,
    output logic                          exp_inc,
    output logic                          inexact,
    output logic                          is_zero
);

    logic [FP_MANT_W-1:0] w_mant;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_round_up;
    logic [FP_MANT_W:0]   w_mant_sum;

    // Bits below the hidden one: mantissa, then guard, then everything else.
    assign w_mant  = mag[MAG_W-2 -: FP_MANT_W];
    assign w_guard = mag[MAG_W-FP_MANT_W-2];

    // At the minimum width there are no bits left below the guard bit.
    generate
        if (MAG_W > FP_MANT_W + 2) begin : g_sticky_bits
            assign w_sticky = |mag[MAG_W-FP_MANT_W-3:0];
        end else begin : g_no_sticky
            assign w_sticky = 1'b0;
        end
    endgenerate

    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {{FP_MANT_W{1'b0}}, w_round_up};

    // A carry out of the mantissa leaves its low bits all zero, so only the
    // exponent needs adjusting.
    assign exp_inc   = w_mant_sum[FP_MANT_W];
    assign packed_em = {exp + FP_EXP_W'(exp_inc), w_mant_sum[FP_MANT_W-1:0]};
    assign inexact   = w_guard | w_sticky;
    // A normalized magnitude without its leading one can only be zero.
    assign is_zero   = ~mag[MAG_W-1];

endmodule
`default_nettype wire

// File: rtl/int_to_float_converter.sv
`default_nettype none
// ============================================================================
// Module      : int_to_float_converter
// Description : Multi-cycle XLEN-bit integer to IEEE-754 single conversion,
//               round to nearest even, one normalization shift per cycle,
//               valid/ready on both sides.
//               Define INT_TO_FLOAT_SIGNED_EN for two's-complement input;
//               otherwise the input is unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_float_converter
    import fp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            inexact
);

    localparam logic [FP_EXP_W-1:0] C_EXP_INIT = FP_EXP_W'(FP_EXP_BIAS + XLEN - 1);

    conv_state_t                    r_state;
    conv_state_t                    w_state_nx;
    logic                           r_sign;
    logic [XLEN-1:0]                r_mag;
    logic [FP_EXP_W-1:0]            r_exp;
    logic [31:0]                    r_out_data;
    logic                           r_inexact;
    logic                           r_out_valid;

    logic                           w_in_sign;
    logic [XLEN-1:0]                w_in_mag;
    logic                           w_norm_done;
    logic [FP_EXP_W+FP_MANT_W-1:0]  w_rnd_em;
    logic                           w_rnd_exp_inc;
    logic                           w_rnd_inexact;
    logic                           w_rnd_zero;

`ifdef INT_TO_FLOAT_SIGNED_EN
    // Absolute value; the most-negative input maps to 1 followed by zeros,
    // which is exactly right for an unsigned magnitude.
    assign w_in_sign = in_data[XLEN-1];
    assign w_in_mag  = w_in_sign ? (~in_data + XLEN'(1)) : in_data;
`else
    assign w_in_sign = 1'b0;
    assign w_in_mag  = in_data;
`endif

    assign w_norm_done = (r_mag == '0) || r_mag[XLEN-1];

    fp_round_rne #(
        .MAG_W (XLEN)
    ) u_round (
        .mag       (r_mag),
        .exp       (r_exp),
        .packed_em (w_rnd_em),
        .exp_inc   (w_rnd_exp_inc),
        .inexact   (w_rnd_inexact),
        .is_zero   (w_rnd_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)    w_state_nx = NORM;
            NORM:    if (w_norm_done) w_state_nx = ROUND;
            ROUND:                    w_state_nx = DONE;
            DONE:    if (out_ready)   w_state_nx = IDLE;
            default:                  w_state_nx = IDLE;
        endcase
    end

    // Datapath: capture, shift-normalize, round and hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_out_data  <= '0;
            r_inexact   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_in_sign;
                        r_mag  <= w_in_mag;
                        r_exp  <= C_EXP_INIT;
                    end
                end
                NORM: begin
                    if (!w_norm_done) begin
                        r_mag <= {r_mag[XLEN-2:0], 1'b0};
                        r_exp <= r_exp - FP_EXP_W'(1);
                    end
                end
                ROUND: begin
                    r_out_data  <= w_rnd_zero ? 32'h0 : {r_sign, w_rnd_em};
                    r_inexact   <= w_rnd_inexact;
                    r_exp       <= r_exp + FP_EXP_W'(w_rnd_exp_inc);
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_to_float_converter
// Description : Directed vector table plus backpressure and reset sequences
//               for int_to_float_converter (XLEN = 32).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_int_to_float_converter;

    localparam int XLEN = 32;
    localparam int NVEC = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [31:0]     out_data;
    logic            inexact;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        inx;
        int          lz;
    } vec_t;

    vec_t vecs [NVEC];

    int_to_float_converter #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Offer one operand, wait for acceptance, then wait for out_valid.
    // lat is the cycle number (acceptance edge = cycle 0) in which
    // out_valid is first high.
    task automatic convert(input logic [31:0] din, output logic [31:0] dout,
                           output logic inx, output int lat, output logic ok);
        int n;
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat  = n + 1;
        dout = out_data;
        inx  = inexact;
        ok   = ok & out_valid;
    endtask

    initial begin
        logic [31:0] dout;
        logic        inx;
        logic        ok;
        int          lat;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 0};
        vecs[1]  = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 31};
        vecs[2]  = '{32'h0000_0003, 32'h4040_0000, 1'b0, 30};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 1};
        vecs[4]  = '{32'h0100_0001, 32'h4B80_0000, 1'b1, 7};
        vecs[5]  = '{32'h0100_0003, 32'h4B80_0002, 1'b1, 7};
        vecs[6]  = '{32'h4000_0000, 32'h4E80_0000, 1'b0, 1};
        vecs[7]  = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 8};
        vecs[8]  = '{32'h01FF_FFFF, 32'h4C00_0000, 1'b1, 7};
        vecs[9]  = '{32'h0000_0005, 32'h40A0_0000, 1'b0, 29};
`ifdef INT_TO_FLOAT_SIGNED_EN
        vecs[10] = '{32'hFFFF_FFF9, 32'hC0E0_0000, 1'b0, 29};
        vecs[11] = '{32'h8000_0000, 32'hCF00_0000, 1'b0, 0};
        vecs[12] = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 31};
`else
        vecs[10] = '{32'hFFFF_FFF9, 32'h4F80_0000, 1'b1, 0};
        vecs[11] = '{32'h8000_0000, 32'h4F00_0000, 1'b0, 0};
        vecs[12] = '{32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 0};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        check("reset inexact", 32'(inexact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven conversions with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            convert(vecs[i].din, dout, inx, lat, ok);
            check($sformatf("vec%0d handshake", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d data", i), dout, vecs[i].dout);
            check($sformatf("vec%0d inexact", i), 32'(inx), 32'(vecs[i].inx));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lz + 3));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid drop", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d idle", i), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d data held", i), out_data, vecs[i].dout);
        end

        // Backpressure: result must stay put and new input is refused
        out_ready = 1'b0;
        convert(32'h7FFF_FFFF, dout, inx, lat, ok);
        check("bp handshake", 32'(ok), 32'd1);
        check("bp data", dout, 32'h4F00_0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h0000_0003;
            @(posedge clk);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_data", out_data, 32'h4F00_0000);
            check("bp inexact", 32'(inexact), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", 32'(out_valid), 32'd0);
        check("bp release idle", 32'(in_ready), 32'd1);
        check("bp release data", out_data, 32'h4F00_0000);
        @(posedge clk);
        #1;
        check("bp single handshake", 32'(out_valid), 32'd0);
        check("bp stays idle", 32'(in_ready), 32'd1);

        // Reset in the middle of normalizing 1
        @(negedge clk);
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid norm busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_data", out_data, 32'h0);
        check("async rst inexact", 32'(inexact), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held rst out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("aborted no result", 32'(out_valid), 32'd0);
        convert(32'h0000_0005, dout, inx, lat, ok);
        check("post rst handshake", 32'(ok), 32'd1);
        check("post rst data", dout, 32'h40A0_0000);
        check("post rst inexact", 32'(inx), 32'd0);
        check("post rst latency", 32'(lat), 32'd32);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
